// File: rtl/bram_arb2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_arb2_pkg
// Brief    : Shared client count and client-id type for the dual-client arbiter
// Revision : 1.0
// ============================================================================
package bram_arb2_pkg;

  localparam int c_NUM_CLIENTS = 2;

  typedef logic client_id_t;

  // Grant vectors are one-hot or zero, so bit 1 alone names the winner.
  function automatic client_id_t onehot_to_id(input logic [c_NUM_CLIENTS-1:0] i_oh);
    return i_oh[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : 2-way round-robin arbiter; pointer remembers the last winner
// Revision : 1.0
// ============================================================================
module rr_arb2
  import bram_arb2_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [c_NUM_CLIENTS-1:0] i_req,
  output logic [c_NUM_CLIENTS-1:0] o_gnt
);

  client_id_t                 r_last;
  logic [c_NUM_CLIENTS-1:0]   w_gnt;

  // On a tie the client that did not win last time goes first.
  always_comb begin
    w_gnt = '0;
    if (!rst) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (|w_gnt) begin
      r_last <= onehot_to_id(w_gnt);
    end
  end

  assign o_gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/bram_arb2.sv
`default_nettype none
// ============================================================================
// Module   : bram_arb2
// Brief    : Two-client read/write arbiter in front of a 1-cycle-latency BRAM
// Revision : 1.0
// ============================================================================
module bram_arb2
  import bram_arb2_pkg::*;
#(
  parameter int width = 32,
  parameter int n     = 5
)(
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [c_NUM_CLIENTS-1:0]         rd_req_valid,
  input  logic [c_NUM_CLIENTS*n-1:0]       rd_req_index,
  output logic [c_NUM_CLIENTS-1:0]         rd_req_ready,
  output logic [c_NUM_CLIENTS-1:0]         rd_resp_valid,
  output logic [c_NUM_CLIENTS*width-1:0]   rd_resp_data,
  input  logic [c_NUM_CLIENTS-1:0]         rd_resp_ready,
  input  logic [c_NUM_CLIENTS-1:0]         wr_valid,
  input  logic [c_NUM_CLIENTS*n-1:0]       wr_index,
  input  logic [c_NUM_CLIENTS*width-1:0]   wr_data,
  output logic [c_NUM_CLIENTS-1:0]         wr_ready,
  output logic                             bram_read_en,
  output logic [n-1:0]                     bram_read_req,
  input  logic [width-1:0]                 bram_read_resp,
  output logic                             bram_write_en,
  output logic [n-1:0]                     bram_write_index,
  output logic [width-1:0]                 bram_write_data
);

  logic [c_NUM_CLIENTS-1:0] w_rd_elig;
  logic [c_NUM_CLIENTS-1:0] w_rd_gnt;
  logic [c_NUM_CLIENTS-1:0] w_wr_gnt;
  client_id_t               w_rd_id;
  client_id_t               w_wr_id;

  logic                     r_fly_valid;
  client_id_t               r_fly_owner;
  logic [c_NUM_CLIENTS-1:0] r_slot_valid;
  logic [width-1:0]         r_slot_data [c_NUM_CLIENTS];

  // A client may issue only when its slot will be free by the time data lands.
  for (genvar i = 0; i < c_NUM_CLIENTS; i++) begin : g_elig
    assign w_rd_elig[i] = rd_req_valid[i] &
                          (~r_slot_valid[i] | rd_resp_ready[i]) &
                          ~(r_fly_valid & (r_fly_owner == client_id_t'(i)));
  end

  rr_arb2 u_rd_arb (
    .clk   (CLK),
    .rst   (RST),
    .i_req (w_rd_elig),
    .o_gnt (w_rd_gnt)
  );

  rr_arb2 u_wr_arb (
    .clk   (CLK),
    .rst   (RST),
    .i_req (wr_valid),
    .o_gnt (w_wr_gnt)
  );

  assign w_rd_id      = onehot_to_id(w_rd_gnt);
  assign w_wr_id      = onehot_to_id(w_wr_gnt);
  assign rd_req_ready = w_rd_gnt;
  assign wr_ready     = w_wr_gnt;
  assign bram_read_en  = |w_rd_gnt;
  assign bram_write_en = |w_wr_gnt;

  always_comb begin
    bram_read_req = '0;
    if (|w_rd_gnt) begin
      bram_read_req = w_rd_id ? rd_req_index[2*n-1:n] : rd_req_index[n-1:0];
    end
  end

  always_comb begin
    bram_write_index = '0;
    bram_write_data  = '0;
    if (|w_wr_gnt) begin
      bram_write_index = w_wr_id ? wr_index[2*n-1:n] : wr_index[n-1:0];
      bram_write_data  = w_wr_id ? wr_data[2*width-1:width] : wr_data[width-1:0];
    end
  end

  // Tracks which client owns the BRAM response arriving next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fly_valid <= 1'b0;
      r_fly_owner <= 1'b0;
    end else begin
      r_fly_valid <= |w_rd_gnt;
      r_fly_owner <= w_rd_id;
    end
  end

  for (genvar i = 0; i < c_NUM_CLIENTS; i++) begin : g_slot
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_slot_valid[i] <= 1'b0;
        r_slot_data[i]  <= '0;
      end else if (r_fly_valid && (r_fly_owner == client_id_t'(i))) begin
        r_slot_valid[i] <= 1'b1;
        r_slot_data[i]  <= bram_read_resp;
      end else if (r_slot_valid[i] && rd_resp_ready[i]) begin
        r_slot_valid[i] <= 1'b0;
      end
    end

    assign rd_resp_valid[i]                  = r_slot_valid[i] & ~RST;
    assign rd_resp_data[i*width +: width]    = r_slot_data[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_arb2
// Brief    : Directed bench with a cycle-level reference model for bram_arb2
// Revision : 1.0
// ============================================================================
module tb_bram_arb2;

  localparam int W = 32;
  localparam int N = 5;

  logic          CLK;
  logic          RST;
  logic          RST_N;
  logic [1:0]    rd_req_valid;
  logic [2*N-1:0] rd_req_index;
  logic [1:0]    rd_req_ready;
  logic [1:0]    rd_resp_valid;
  logic [2*W-1:0] rd_resp_data;
  logic [1:0]    rd_resp_ready;
  logic [1:0]    wr_valid;
  logic [2*N-1:0] wr_index;
  logic [2*W-1:0] wr_data;
  logic [1:0]    wr_ready;
  logic          bram_read_en;
  logic [N-1:0]  bram_read_req;
  logic [W-1:0]  bram_read_resp;
  logic          bram_write_en;
  logic [N-1:0]  bram_write_index;
  logic [W-1:0]  bram_write_data;

  int checks   = 0;
  int failures = 0;

  bram_arb2 #(.width(W), .n(N)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .rd_req_valid     (rd_req_valid),
    .rd_req_index     (rd_req_index),
    .rd_req_ready     (rd_req_ready),
    .rd_resp_valid    (rd_resp_valid),
    .rd_resp_data     (rd_resp_data),
    .rd_resp_ready    (rd_resp_ready),
    .wr_valid         (wr_valid),
    .wr_index         (wr_index),
    .wr_data          (wr_data),
    .wr_ready         (wr_ready),
    .bram_read_en     (bram_read_en),
    .bram_read_req    (bram_read_req),
    .bram_read_resp   (bram_read_resp),
    .bram_write_en    (bram_write_en),
    .bram_write_index (bram_write_index),
    .bram_write_data  (bram_write_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // BRAM: 1-cycle read latency, write-first; garbage when no read was issued.
  assign RST_N = ~RST;
  logic [W-1:0] mem [32];
  bit           mem_init = 1'b0;
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
      mem_init <= 1'b1;
    end else if (bram_write_en) begin
      mem[bram_write_index] <= bram_write_data;
    end
    if (!RST_N || !bram_read_en)
      bram_read_resp <= 32'hBAD0_BAD0;
    else if (bram_write_en && bram_write_index == bram_read_req)
      bram_read_resp <= bram_write_data;
    else
      bram_read_resp <= mem_init ? mem[bram_read_req] : 32'hA000_0000 + bram_read_req;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] req, input int last);
    if (req == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
    return req;
  endfunction

  // Reference model: a flat memory, two response slots and one pending read.
  logic [W-1:0] m_mem [32];
  bit           m_init = 1'b0;
  logic [1:0]   m_sv;
  logic [W-1:0] m_sd [2];
  bit           m_fly_v;
  int           m_fly_c;
  logic [W-1:0] m_fly_d;
  int           m_last_rd;
  int           m_last_wr;

  always @(negedge CLK) begin
    logic [1:0]   el;
    logic [1:0]   eg;
    logic [1:0]   wg;
    logic [N-1:0] ri;
    logic [N-1:0] wi;
    logic [W-1:0] wd;
    if (!m_init) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'hA000_0000 + i;
      m_init = 1'b1;
    end
    if (RST) begin
      chk("rst_rd_ready", rd_req_ready, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_resp_valid", rd_resp_valid, 0);
      chk("rst_read_en", bram_read_en, 0);
      chk("rst_write_en", bram_write_en, 0);
      m_sv = 2'b00; m_fly_v = 0; m_fly_c = 0; m_fly_d = '0;
      m_last_rd = 1; m_last_wr = 1;
    end else begin
      for (int i = 0; i < 2; i++)
        el[i] = rd_req_valid[i] && (!m_sv[i] || rd_resp_ready[i]) && !(m_fly_v && m_fly_c == i);
      eg = pick(el, m_last_rd);
      wg = pick(wr_valid, m_last_wr);
      ri = eg[1] ? rd_req_index[2*N-1:N] : rd_req_index[N-1:0];
      wi = wg[1] ? wr_index[2*N-1:N] : wr_index[N-1:0];
      wd = wg[1] ? wr_data[2*W-1:W] : wr_data[W-1:0];
      chk("rd_req_ready", rd_req_ready, eg);
      chk("bram_read_en", bram_read_en, |eg);
      chk("bram_read_req", bram_read_req, (eg != 0) ? ri : 0);
      chk("wr_ready", wr_ready, wg);
      chk("bram_write_en", bram_write_en, |wg);
      if (wg != 0) begin
        chk("bram_write_index", bram_write_index, wi);
        chk("bram_write_data", bram_write_data, wd);
      end
      chk("rd_resp_valid", rd_resp_valid, m_sv);
      if (m_sv[0]) chk("rd_resp_data0", rd_resp_data[W-1:0], m_sd[0]);
      if (m_sv[1]) chk("rd_resp_data1", rd_resp_data[2*W-1:W], m_sd[1]);
      // advance to the next cycle
      for (int i = 0; i < 2; i++) begin
        if (m_fly_v && m_fly_c == i) begin
          m_sv[i] = 1'b1; m_sd[i] = m_fly_d;
        end else if (m_sv[i] && rd_resp_ready[i]) begin
          m_sv[i] = 1'b0;
        end
      end
      m_fly_v = (eg != 0);
      m_fly_c = eg[1] ? 1 : 0;
      m_fly_d = (wg != 0 && wi == ri) ? wd : m_mem[ri];
      if (wg != 0) m_mem[wi] = wd;
      if (eg != 0) m_last_rd = eg[1] ? 1 : 0;
      if (wg != 0) m_last_wr = wg[1] ? 1 : 0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int served;
    RST = 1'b1;
    rd_req_valid = 2'b11; rd_req_index = '0; rd_resp_ready = 2'b11;
    wr_valid = 2'b11; wr_index = '0; wr_data = '0;
    repeat (3) tick();
    @(negedge CLK);
    chk("lit_rst_grants", {rd_req_ready, wr_ready, bram_read_en, bram_write_en}, 0);

    // Write 0xDEADBEEF to idx 3 from client 0, read it back on client 1
    tick();
    RST = 1'b0; rd_req_valid = 2'b00;
    wr_valid = 2'b01; wr_index = {5'd0, 5'd3}; wr_data = {32'h0, 32'hDEADBEEF};
    @(negedge CLK); chk("lit_wr3_ready", wr_ready, 2'b01);
    tick();
    wr_valid = 2'b00; rd_req_valid = 2'b10; rd_req_index = {5'd3, 5'd0}; rd_resp_ready = 2'b00;
    @(negedge CLK); chk("lit_rd3_ready", rd_req_ready, 2'b10);
    tick();
    rd_req_valid = 2'b00;
    @(negedge CLK); chk("lit_rd3_t1_valid", rd_resp_valid[1], 1'b0);
    tick();
    @(negedge CLK);
    chk("lit_rd3_t2_valid", rd_resp_valid[1], 1'b1);
    chk("lit_rd3_data", rd_resp_data[2*W-1:W], 32'hDEADBEEF);
    tick();
    rd_resp_ready = 2'b11;

    // Round-robin streaming after reset
    tick(); RST = 1'b1;
    tick(); RST = 1'b0; rd_req_valid = 2'b11; rd_req_index = {5'd1, 5'd0};
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("lit_rr_seq", rd_req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("lit_rr_read_en", bram_read_en, 1'b1);
      tick();
    end

    // Client 0 stalls its response; client 1 keeps being served
    rd_resp_ready = 2'b10;
    repeat (4) tick();
    rd_req_index = {5'd1, 5'd9};
    served = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("lit_stall_ready0", rd_req_ready[0], 1'b0);
      chk("lit_stall_valid0", rd_resp_valid[0], 1'b1);
      chk("lit_stall_data0", rd_resp_data[W-1:0], 32'hA000_0000);
      if (rd_req_ready[1]) served++;
      tick();
    end
    chk("lit_stall_c1_served", served, 2);
    rd_resp_ready = 2'b11;
    @(negedge CLK); chk("lit_resume_ready0", rd_req_ready[0], 1'b1);
    tick();
    tick();
    @(negedge CLK);
    chk("lit_resume_valid0", rd_resp_valid[0], 1'b1);
    chk("lit_resume_data0", rd_resp_data[W-1:0], 32'hA000_0009);
    tick();

    // Simultaneous writes to idx 5
    rd_req_valid = 2'b00;
    wr_valid = 2'b11; wr_index = {5'd5, 5'd5}; wr_data = {32'h22, 32'h11};
    @(negedge CLK); chk("lit_wr5_first", wr_ready, 2'b01);
    tick();
    wr_valid = 2'b10;
    @(negedge CLK); chk("lit_wr5_second", wr_ready, 2'b10);
    tick();
    wr_valid = 2'b00; rd_req_valid = 2'b01; rd_req_index = {5'd0, 5'd5};
    @(negedge CLK); chk("lit_rd5_ready", rd_req_ready, 2'b01);
    tick();
    rd_req_valid = 2'b00;
    tick();
    @(negedge CLK);
    chk("lit_rd5_valid", rd_resp_valid[0], 1'b1);
    chk("lit_rd5_data", rd_resp_data[W-1:0], 32'h22);
    tick();

    // Same-cycle write and read of idx 7
    wr_valid = 2'b10; wr_index = {5'd7, 5'd0}; wr_data = {32'h1234, 32'h0};
    rd_req_valid = 2'b01; rd_req_index = {5'd0, 5'd7};
    @(negedge CLK); chk("lit_wf_grants", {rd_req_ready, wr_ready}, 4'b0110);
    tick();
    wr_valid = 2'b00; rd_req_valid = 2'b00;
    tick();
    @(negedge CLK);
    chk("lit_wf_valid", rd_resp_valid[0], 1'b1);
    chk("lit_wf_data", rd_resp_data[W-1:0], 32'h1234);
    tick();

    // Reset right after a read grant drops the response
    rd_req_valid = 2'b01; rd_req_index = {5'd0, 5'd3};
    @(negedge CLK); chk("lit_drop_grant", rd_req_ready, 2'b01);
    tick();
    RST = 1'b1; rd_req_valid = 2'b00;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); chk("lit_drop_no_resp", rd_resp_valid, 2'b00);
      tick();
    end
    rd_req_valid = 2'b11; rd_req_index = {5'd2, 5'd4};
    @(negedge CLK); chk("lit_post_rst_tie", rd_req_ready, 2'b01);
    tick();
    rd_req_valid = 2'b00;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_arb2.md
BRAM_ARB2 -- requirements
Module: bram_arb2

Interface
Parameters:
REQ-001 SHALL have parameter width, default 32, data width.
REQ-002 SHALL have parameter n, default 5, index width.
Ports (client vectors: bit/slice i belongs to client i, i in {0,1}):
REQ-003 SHALL have port CLK  in  1  sole clock; one clock; all state updates on posedge CLK.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port rd_req_valid  in  2  read request valid, per client.
REQ-006 SHALL have port rd_req_index  in  2*n  read index, per client.
REQ-007 SHALL have port rd_req_ready  out  2  read request accepted (grant), per client.
REQ-008 SHALL have port rd_resp_valid  out  2  read data valid, per client.
REQ-009 SHALL have port rd_resp_data  out  2*width  read data, per client.
REQ-010 SHALL have port rd_resp_ready  in  2  read data consumed, per client.
REQ-011 SHALL have port wr_valid  in  2  write request valid, per client.
REQ-012 SHALL have port wr_index  in  2*n  write index, per client.
REQ-013 SHALL have port wr_data  in  2*width  write data, per client.
REQ-014 SHALL have port wr_ready  out  2  write accepted, per client.
REQ-015 SHALL have port bram_read_en  out  1  to BRAM READ_EN_WRITE.
REQ-016 SHALL have port bram_read_req  out  n  to BRAM READ_REQ_WRITE.
REQ-017 SHALL have port bram_read_resp  in  width  from BRAM READ_RESP_READ; valid exactly 1 cycle after the address is presented.
REQ-018 SHALL have port bram_write_en  out  1  to BRAM WRITE_EN_WRITE.
REQ-019 SHALL have port bram_write_index  out  n  to BRAM WRITE_INDEX_WRITE.
REQ-020 SHALL have port bram_write_data  out  width  to BRAM WRITE_DATA_WRITE.

Function
REQ-021 Read eligibility of client i SHALL be: rd_req_valid[i] AND (slot i empty OR rd_resp_ready[i]) AND no in-flight read owned by i.
REQ-022 At most one read grant per cycle SHALL be issued; with both eligible, priority goes to the client not granted last (round-robin); the read pointer SHALL update only on a grant.
REQ-023 rd_req_ready SHALL be combinational, one-hot or zero; on a grant bram_read_en=1 and bram_read_req=the granted index; with no grant bram_read_en=0 and bram_read_req=0.
REQ-024 A read granted in cycle t SHALL set in-flight{owner} in t+1; bram_read_resp is captured into slot[owner] at the end of t+1, so rd_resp_valid[owner]=1 from t+2 (2-cycle accept-to-valid latency).
REQ-025 Slot i SHALL hold rd_resp_data stable while rd_resp_valid[i]=1 and rd_resp_ready[i]=0, and SHALL clear on valid AND ready unless refilled the same cycle.
REQ-026 Write grant SHALL use an independent round-robin pointer over wr_valid; one write per cycle; wr_ready combinational one-hot or zero; the granted index/data drive the BRAM with bram_write_en=1.
REQ-027 Read and write grants SHALL be independent and allowed in the same cycle.
REQ-028 A same-cycle write and read to one index SHALL return the new data (write-first, set by BRAM timing).
REQ-029 The block SHALL NOT use bram_read_resp in any cycle that does not follow a read grant.

Reset
REQ-030 While RST=1, slots and in-flight SHALL be cleared, and both pointers SHALL be set so client 0 wins the next tie.
REQ-031 While RST=1, all ready, valid and bram_*_en outputs SHALL be 0.
REQ-032 A read in flight at reset SHALL be dropped and never delivered.
REQ-033 The BRAM instance SHALL receive RST_N = NOT RST at the top level.

Structure
REQ-034 Shared package SHALL hold the client count (2) and the client-id type.
REQ-035 One sub-module, rr_arb2 (2-way round-robin arbiter with pointer), SHALL be instantiated twice, once for reads and once for writes.

Verification (width=32, n=5, BRAM size=32)
REQ-036 Client0 writes idx 3 = 0xDEADBEEF; client1 then reads idx 3 -> rd_resp_valid[1] asserts 2 cycles after accept, data 0xDEADBEEF.
REQ-037 After reset, both clients read continuously with rd_resp_ready=11 -> grants go 0,1,0,1,...; one bram read per cycle.
REQ-038 Client0 rd_resp_ready=0 with slot full -> rd_req_ready[0]=0, data held stable, client1 still served; raising ready resumes client0 the same cycle.
REQ-039 Both write idx 5 in the same cycle (0x11, 0x22) -> client0 accepted first, client1 next cycle; a later read of idx 5 returns 0x22.
REQ-040 Same-cycle write idx 7 = 0x1234 and read idx 7 -> response 0x1234.
REQ-041 RST pulsed the cycle after a read grant -> that response never appears; next tie after reset is granted to client 0.
